mac_vec: RTL

Parametrised vector multiply-accumulate engine; successor to the scalar single-lane MAC in the datapath. Each accepted beat multiplies LANES operand pairs, sums them through a registered adder tree and accumulates the sum into a wide saturating accumulator. The accumulated result is presented when a beat tagged in_last retires. Output uses a valid/ready handshake with full-pipeline backpressure, and signed or unsigned arithmetic is selected per beat.

---
 rtl/mac_pkg.sv | 62 ++++++
 rtl/mac_vec_if.sv | 31 +++
 rtl/mac_lane.sv | 41 ++++
 rtl/mac_vec.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the vector MAC: width helpers and the saturating adder
// used by the accumulator stage.
package mac_pkg;

  localparam int SAT_W = 128;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] sum;
  } sat_res_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int acc_w_default(input int width);
    return 2 * width + 8;
  endfunction

  // Operands arrive pre-extended to SAT_W in the beat's mode; the result is clamped to a w-bit range.
  function automatic sat_res_t sat_add(input logic sgn, input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b, input int w);
    sat_res_t         r;
    logic [SAT_W-1:0] raw;
    logic [SAT_W-1:0] hi;
    logic [SAT_W-1:0] lo;
    raw = a + b;
    r.ovf = 1'b0;
    r.sum = raw;
    if (sgn) begin
      hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
      lo = ~hi;
      if ($signed(raw) > $signed(hi)) begin
        r.ovf = 1'b1;
        r.sum = hi;
      end else if ($signed(raw) < $signed(lo)) begin
        r.ovf = 1'b1;
        r.sum = lo;
      end else begin
        r.sum = raw;
      end
    end else begin
      hi = (SAT_W'(1) << w) - SAT_W'(1);
      if (raw > hi) begin
        r.ovf = 1'b1;
        r.sum = hi;
      end else begin
        r.sum = raw;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_vec_if.sv
// Beat input and result output bundle of the vector MAC; master drives beats,
// slave is the engine.
interface mac_vec_if import mac_pkg::*; #(
  parameter int WIDTH = 36,
  parameter int LANES = 4,
  parameter int ACC_W = acc_w_default(WIDTH),
  parameter int CNT_W = 8
);
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic                   in_signed;
  logic                   in_last;
  logic                   in_valid;
  logic                   in_ready;
  logic                   mac_reset;
  logic [ACC_W-1:0]       out;
  logic                   out_sat;
  logic [CNT_W-1:0]       out_count;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_a, in_b, in_signed, in_last, in_valid, mac_reset, out_ready,
    input  in_ready, out, out_sat, out_count, out_valid
  );

  modport slave (
    input  in_a, in_b, in_signed, in_last, in_valid, mac_reset, out_ready,
    output in_ready, out, out_sat, out_count, out_valid
  );
endinterface

// File: rtl/mac_lane.sv
// One multiplier lane: registered full-width product, sign- or zero-extended
// operands depending on the beat's mode.
module mac_lane #(
  parameter int WIDTH = 36
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic [2*WIDTH-1:0] prod
);
  logic [2*WIDTH-1:0] a_x_s;
  logic [2*WIDTH-1:0] b_x_s;
  logic [2*WIDTH-1:0] prod_r;

  // Extend both operands to full product width, then multiply
  always_comb begin
    a_x_s = {{WIDTH{1'b0}}, a};
    b_x_s = {{WIDTH{1'b0}}, b};
    if (sgn) begin
      a_x_s = {{WIDTH{a[WIDTH-1]}}, a};
      b_x_s = {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      a_x_s = {{WIDTH{1'b0}}, a};
      b_x_s = {{WIDTH{1'b0}}, b};
    end
  end

  // Product register, held while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r <= '0;
    end else if (en) begin
      prod_r <= a_x_s * b_x_s;
    end
  end

  assign prod = prod_r;
endmodule

// File: rtl/mac_vec.sv
// Vector multiply-accumulate: lane products, registered adder tree and a
// saturating accumulator that emits a result on each last beat.
module mac_vec import mac_pkg::*; #(
  parameter int WIDTH = 36,
  parameter int LANES = 4,
  parameter int ACC_W = acc_w_default(WIDTH),
  parameter int CNT_W = 8
) (
  input logic      clk,
  input logic      rst,
  mac_vec_if.slave bus
);
  localparam int TREE_W = 2 * WIDTH + clog2(LANES);

  logic               en_s;
  logic [2*WIDTH-1:0] prod_s [LANES];
  logic [TREE_W-1:0]  tree_s;
  logic [ACC_W-1:0]   sum_x_s;
  logic               s1_valid_r, s1_last_r, s1_sgn_r;
  logic               s2_valid_r, s2_last_r, s2_sgn_r;
  logic [ACC_W-1:0]   s2_sum_r;
  logic [ACC_W-1:0]   acc_r;
  logic               sticky_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_inc_s;
  sat_res_t           sat_s;
  logic [ACC_W-1:0]   next_s;
  logic               ovf_s;
  logic               unused_sum_s;
  logic [ACC_W-1:0]   out_r;
  logic               out_sat_r;
  logic [CNT_W-1:0]   out_count_r;
  logic               out_valid_r;

  // The whole pipeline advances only when no result is stuck at the output.
  assign en_s         = !out_valid_r || bus.out_ready;
  assign bus.in_ready = en_s;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.WIDTH(WIDTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en_s),
      .a    (bus.in_a[i*WIDTH +: WIDTH]),
      .b    (bus.in_b[i*WIDTH +: WIDTH]),
      .sgn  (bus.in_signed),
      .prod (prod_s[i])
    );
  end

  // Adder tree over lane products, widened to accumulator width in the beat's mode
  always_comb begin
    tree_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_sgn_r) begin
        tree_s = tree_s + TREE_W'($signed(prod_s[i]));
      end else begin
        tree_s = tree_s + TREE_W'(prod_s[i]);
      end
    end
    if (s1_sgn_r) begin
      sum_x_s = ACC_W'($signed(tree_s));
    end else begin
      sum_x_s = ACC_W'(tree_s);
    end
  end

  // Saturating accumulate and saturating beat count for the beat in S3
  always_comb begin
    if (s2_sgn_r) begin
      sat_s = sat_add(1'b1, SAT_W'($signed(acc_r)), SAT_W'($signed(s2_sum_r)), ACC_W);
    end else begin
      sat_s = sat_add(1'b0, SAT_W'(acc_r), SAT_W'(s2_sum_r), ACC_W);
    end
    next_s = sat_s.sum[ACC_W-1:0];
    ovf_s  = sat_s.ovf;
    if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end
  end

  assign unused_sum_s = ^sat_s.sum[SAT_W-1:ACC_W];

  // S1/S2 beat tags and tree sum; mac_reset flushes whatever is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_sgn_r   <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_sgn_r   <= 1'b0;
      s2_sum_r   <= '0;
    end else if (bus.mac_reset) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else if (en_s) begin
      s1_valid_r <= bus.in_valid;
      s1_last_r  <= bus.in_last;
      s1_sgn_r   <= bus.in_signed;
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_last_r;
      s2_sgn_r   <= s1_sgn_r;
      s2_sum_r   <= sum_x_s;
    end
  end

  // Accumulator, counter and result register; a pending result survives mac_reset
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= '0;
      sticky_r    <= 1'b0;
      cnt_r       <= '0;
      out_r       <= '0;
      out_sat_r   <= 1'b0;
      out_count_r <= '0;
      out_valid_r <= 1'b0;
    end else begin
      // With en high any held result is being consumed this edge.
      if (en_s) begin
        out_valid_r <= 1'b0;
      end
      if (bus.mac_reset) begin
        acc_r    <= '0;
        sticky_r <= 1'b0;
        cnt_r    <= '0;
      end else if (en_s && s2_valid_r) begin
        if (s2_last_r) begin
          out_r       <= next_s;
          out_sat_r   <= sticky_r | ovf_s;
          out_count_r <= cnt_inc_s;
          out_valid_r <= 1'b1;
          acc_r       <= '0;
          sticky_r    <= 1'b0;
          cnt_r       <= '0;
        end else begin
          acc_r    <= next_s;
          sticky_r <= sticky_r | ovf_s;
          cnt_r    <= cnt_inc_s;
        end
      end
    end
  end

  assign bus.out       = out_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.out_count = out_count_r;
  assign bus.out_valid = out_valid_r;
endmodule
